mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a latched decode.
// Define MCCU_TRAP_EN to send illegal instructions to a sticky TRAP state instead of treating them as NOPs.
module mc_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               br,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               pc_to_reg,
    output logic               alu_to_pc,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               halted,
    output logic               illegal,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_HALT = 3'd5, S_TRAP = 3'd6, S_IDLE = 3'd7
    } state_t;

    typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_B, C_JAL, C_JALR, C_HALT} cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] op;
    } dec_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_MUL = 4'd2, ALU_AND = 4'd3,
                           ALU_OR  = 4'd4, ALU_SLL = 4'd5, ALU_XOR = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8, ALU_SLT = 4'd9;
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    state_t           state_q, state_d;
    dec_t             dec_q;
    logic [CNT_W-1:0] cnt_q;
    cls_t             d_cls;
    logic [3:0]       d_op;
    logic             d_legal;
    logic             is_mul, mul_done;

    always_comb begin
        d_cls   = C_R;
        d_op    = ALU_ADD;
        d_legal = 1'b1;
        case (opcode)
            7'b0110011: begin
                d_cls = C_R;
                case (func3)
                    3'b000: case (func7)
                        7'b0000000: d_op = ALU_ADD;
                        7'b0100000: d_op = ALU_SUB;
                        7'b0000001: d_op = ALU_MUL;
                        default:    d_legal = 1'b0;
                    endcase
                    3'b111: d_op = ALU_AND;
                    3'b110: d_op = ALU_OR;
                    3'b001: d_op = ALU_SLL;
                    3'b100: d_op = ALU_XOR;
                    3'b010: d_op = ALU_SLT;
                    3'b101: case (func7)
                        7'b0000000: d_op = ALU_SRL;
                        7'b0100000: d_op = ALU_SRA;
                        default:    d_legal = 1'b0;
                    endcase
                    default: d_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                d_cls = C_I;
                case (func3)
                    3'b000:  d_op = ALU_ADD;
                    3'b001:  d_op = ALU_SLL;
                    3'b100:  d_op = ALU_XOR;
                    3'b110:  d_op = ALU_OR;
                    3'b111:  d_op = ALU_AND;
                    default: d_legal = 1'b0;
                endcase
            end
            7'b0000011: d_cls = C_LW;
            7'b0100011: d_cls = C_SW;
            7'b1100011: begin d_cls = C_B; d_op = ALU_SUB; end
            7'b1101111: d_cls = C_JAL;
            7'b1100111: d_cls = C_JALR;
            7'b1111111: d_cls = C_HALT;
            default:    d_legal = 1'b0;
        endcase
    end

    assign is_mul   = (dec_q.cls == C_R) && (dec_q.op == ALU_MUL);
    assign mul_done = (cnt_q == CNT_W'(MUL_LATENCY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) dec_q <= {d_cls, d_op};
            // Counter only runs while in EXEC, so it is zero on every EXEC entry.
            cnt_q <= (state_q == S_EXEC) ? cnt_q + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        br         = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        alu_to_pc  = 1'b0;
        alu_op     = '0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!d_legal) begin
`ifdef MCCU_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
`endif
                end else if (d_cls == C_HALT) state_d = S_HALT;
                else                          state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_op[3:0] = dec_q.op;
                alu_src = (dec_q.cls inside {C_I, C_LW, C_SW, C_JALR});
                if (!is_mul || mul_done) begin
                    case (dec_q.cls)
                        C_B: begin
                            br       = 1'b1;
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end
                        C_LW, C_SW: state_d = S_MEM;
                        default:    state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                mem_read  = (dec_q.cls == C_LW);
                mem_write = (dec_q.cls != C_LW);
                if (mem_ready) begin
                    if (dec_q.cls == C_LW) state_d = S_WB;
                    else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (dec_q.cls == C_LW);
                br         = (dec_q.cls inside {C_JAL, C_JALR});
                pc_to_reg  = (dec_q.cls inside {C_JAL, C_JALR});
                alu_to_pc  = (dec_q.cls == C_JALR);
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
`ifdef MCCU_TRAP_EN
            S_TRAP: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Reset gates every output directly so nothing decoded from the old state can pulse.
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            br         = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            pc_to_reg  = 1'b0;
            alu_to_pc  = 1'b0;
            alu_op     = '0;
            halted     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle against hand-computed states and strobes.
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       mem_ready = 1'b1;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write;
    logic       br, alu_src, mem_to_reg, pc_to_reg, alu_to_pc;
    logic [3:0] alu_op;
    logic       halted, illegal;
    logic [2:0] state;

    mc_control_unit #(.ALUOP_W(4), .MUL_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .br(br),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
        .alu_to_pc(alu_to_pc), .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    // {mem_read, mem_write, ir_write, pc_write, reg_write, br, alu_src, mem_to_reg, pc_to_reg, alu_to_pc, halted, illegal}
    wire [11:0] outs = {mem_read, mem_write, ir_write, pc_write, reg_write, br,
                        alu_src, mem_to_reg, pc_to_reg, alu_to_pc, halted, illegal};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic now_is(input string tag, input logic [2:0] st, input logic [11:0] o, input logic [3:0] op);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".outs"}, 32'(outs), 32'(o));
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] o, input logic [3:0] op);
        @(posedge clk);
        @(negedge clk);
        now_is(tag, st, o, op);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        opcode = o;
        func3  = f3;
        func7  = f7;
    endtask

    localparam logic [11:0] O_FETCH = 12'hA00, O_WB = 12'h180, O_SRC = 12'h020;

    initial begin
        #1 rst_n = 1'b0;
        #1 now_is("reset", 3'd7, 12'h000, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 now_is("idle", 3'd7, 12'h000, 4'd0);
        instr(7'b0110011, 3'b000, 7'b0000000);
        @(negedge clk);
        now_is("fetch0", 3'd0, O_FETCH, 4'd0);

        // ADD
        cyc("add.dec", 3'd1, 12'h000, 4'd0);
        cyc("add.ex", 3'd2, 12'h000, 4'd0);
        cyc("add.wb", 3'd4, O_WB, 4'd0);
        cyc("add.f", 3'd0, O_FETCH, 4'd0);

        // MUL holds EXEC for three cycles
        instr(7'b0110011, 3'b000, 7'b0000001);
        cyc("mul.dec", 3'd1, 12'h000, 4'd0);
        for (int i = 0; i < 3; i++) cyc($sformatf("mul.ex%0d", i), 3'd2, 12'h000, 4'd2);
        cyc("mul.wb", 3'd4, O_WB, 4'd0);
        cyc("mul.f", 3'd0, O_FETCH, 4'd0);

        // SUB, SRA, SLT
        instr(7'b0110011, 3'b000, 7'b0100000);
        cyc("sub.dec", 3'd1, 12'h000, 4'd0);
        cyc("sub.ex", 3'd2, 12'h000, 4'd1);
        cyc("sub.wb", 3'd4, O_WB, 4'd0);
        cyc("sub.f", 3'd0, O_FETCH, 4'd0);
        instr(7'b0110011, 3'b101, 7'b0100000);
        cyc("sra.dec", 3'd1, 12'h000, 4'd0);
        cyc("sra.ex", 3'd2, 12'h000, 4'd8);
        cyc("sra.wb", 3'd4, O_WB, 4'd0);
        cyc("sra.f", 3'd0, O_FETCH, 4'd0);
        instr(7'b0110011, 3'b010, 7'b0000000);
        cyc("slt.dec", 3'd1, 12'h000, 4'd0);
        cyc("slt.ex", 3'd2, 12'h000, 4'd9);
        cyc("slt.wb", 3'd4, O_WB, 4'd0);
        cyc("slt.f", 3'd0, O_FETCH, 4'd0);

        // ORI
        instr(7'b0010011, 3'b110, 7'b0000000);
        cyc("ori.dec", 3'd1, 12'h000, 4'd0);
        cyc("ori.ex", 3'd2, O_SRC, 4'd4);
        cyc("ori.wb", 3'd4, O_WB, 4'd0);
        cyc("ori.f", 3'd0, O_FETCH, 4'd0);

        // LW with two memory wait cycles
        instr(7'b0000011, 3'b010, 7'b0000000);
        cyc("lw.dec", 3'd1, 12'h000, 4'd0);
        cyc("lw.ex", 3'd2, O_SRC, 4'd0);
        mem_ready = 1'b0;
        cyc("lw.mem0", 3'd3, 12'h800, 4'd0);
        cyc("lw.mem1", 3'd3, 12'h800, 4'd0);
        cyc("lw.mem2", 3'd3, 12'h800, 4'd0);
        mem_ready = 1'b1;
        cyc("lw.wb", 3'd4, 12'h190, 4'd0);
        cyc("lw.f", 3'd0, O_FETCH, 4'd0);

        // SW
        instr(7'b0100011, 3'b010, 7'b0000000);
        cyc("sw.dec", 3'd1, 12'h000, 4'd0);
        cyc("sw.ex", 3'd2, O_SRC, 4'd0);
        cyc("sw.mem", 3'd3, 12'h500, 4'd0);
        cyc("sw.f", 3'd0, O_FETCH, 4'd0);

        // Branch
        instr(7'b1100011, 3'b000, 7'b0000000);
        cyc("b.dec", 3'd1, 12'h000, 4'd0);
        cyc("b.ex", 3'd2, 12'h140, 4'd1);
        cyc("b.f", 3'd0, O_FETCH, 4'd0);

        // JAL, JALR
        instr(7'b1101111, 3'b000, 7'b0000000);
        cyc("jal.dec", 3'd1, 12'h000, 4'd0);
        cyc("jal.ex", 3'd2, 12'h000, 4'd0);
        cyc("jal.wb", 3'd4, 12'h1C8, 4'd0);
        cyc("jal.f", 3'd0, O_FETCH, 4'd0);
        instr(7'b1100111, 3'b000, 7'b0000000);
        cyc("jalr.dec", 3'd1, 12'h000, 4'd0);
        cyc("jalr.ex", 3'd2, O_SRC, 4'd0);
        cyc("jalr.wb", 3'd4, 12'h1CC, 4'd0);
        cyc("jalr.f", 3'd0, O_FETCH, 4'd0);

        // Illegal opcode
        instr(7'b0001111, 3'b000, 7'b0000000);
`ifdef MCCU_TRAP_EN
        cyc("ill.dec", 3'd1, 12'h000, 4'd0);
        for (int i = 0; i < 3; i++) cyc($sformatf("ill.trap%0d", i), 3'd6, 12'h003, 4'd0);
        rst_n = 1'b0;
        #1 now_is("ill.rst", 3'd7, 12'h000, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("ill.f", 3'd0, O_FETCH, 4'd0);
`else
        cyc("ill.dec", 3'd1, 12'h100, 4'd0);
        cyc("ill.f", 3'd0, O_FETCH, 4'd0);
`endif

        // HALT is terminal
        instr(7'b1111111, 3'b000, 7'b0000000);
        cyc("halt.dec", 3'd1, 12'h000, 4'd0);
        for (int i = 0; i < 20; i++) cyc($sformatf("halt%0d", i), 3'd5, 12'h002, 4'd0);

        // Reset mid-FETCH while memory stalls
        rst_n = 1'b0;
        #1 now_is("halt.rst", 3'd7, 12'h000, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        instr(7'b0110011, 3'b000, 7'b0000000);
        cyc("stall.f0", 3'd0, 12'h800, 4'd0);
        cyc("stall.f1", 3'd0, 12'h800, 4'd0);
        #2 rst_n = 1'b0;
        #1 now_is("midf.rst", 3'd7, 12'h000, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 now_is("midf.idle", 3'd7, 12'h000, 4'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        cyc("midf.f", 3'd1, 12'h000, 4'd0);
        cyc("midf.ex", 3'd2, 12'h000, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
